// File: rtl/clint_trap_ctrl_pkg.sv
// Shared constants for the trap sequencer: CSR addresses, cause codes,
// mstatus bit positions and the FSM state encoding.
package clint_trap_ctrl_pkg;

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

    localparam logic [63:0] CAUSE_MTI     = 64'h8000_0000_0000_0007;
    localparam logic [63:0] CAUSE_ECALL_M = 64'h0000_0000_0000_000B;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_W_MEPC    = 3'd1,
        ST_W_MCAUSE  = 3'd2,
        ST_W_MSTATUS = 3'd3,
        ST_R_MSTATUS = 3'd4,
        ST_JUMP      = 3'd5
    } state_e;

endpackage

// File: rtl/clint_trap_ctrl_if.sv
// CLINT-side CSR write port and fetch redirect, bundled as one bus.
// The master is the trap sequencer; the slave side is the CSR file / PC mux.
interface clint_trap_ctrl_if #(
    parameter int XLEN = 64
);
    logic            cpu_csr_wen_i;
    logic            clint_csr_wen_o;
    logic [11:0]     clint_csr_waddr_o;
    logic [XLEN-1:0] clint_csr_wdata_o;
    logic            redirect_valid_o;
    logic [XLEN-1:0] redirect_pc_o;

    modport master (
        input  cpu_csr_wen_i,
        output clint_csr_wen_o,
        output clint_csr_waddr_o,
        output clint_csr_wdata_o,
        output redirect_valid_o,
        output redirect_pc_o
    );

    modport slave (
        output cpu_csr_wen_i,
        input  clint_csr_wen_o,
        input  clint_csr_waddr_o,
        input  clint_csr_wdata_o,
        input  redirect_valid_o,
        input  redirect_pc_o
    );
endinterface

// File: rtl/clint_trap_ctrl_trap_vec_calc.sv
// Trap target computation from mtvec. Vectored mode only applies to
// interrupts; exceptions always land on the base address.
module trap_vec_calc #(
    parameter int VECTORED_EN = 1,
    parameter int XLEN        = 64
) (
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [5:0]      cause_idx_i,
    input  logic            is_int_i,
    output logic [XLEN-1:0] target_o
);

    logic [XLEN-1:0] base;
    logic [XLEN-1:0] offset;

    // Base is mtvec with MODE bits cleared; vectored offset is 4*cause.
    always_comb begin
        base   = {mtvec_i[XLEN-1:2], 2'b00};
        offset = XLEN'({cause_idx_i, 2'b00});
        if ((VECTORED_EN != 0) && is_int_i && (mtvec_i[1:0] == 2'b01)) begin
            target_o = base + offset;
        end else begin
            target_o = base;
        end
    end

endmodule

// File: rtl/clint_trap_ctrl.sv
// Trap/interrupt sequencer. Stalls the pipeline on ecall, timer interrupt
// or mret, issues the CSR writes one per cycle through the CLINT port,
// then strobes a PC redirect.
//
// state        | meaning
// ST_IDLE      | waiting for a valid instruction that traps or returns
// ST_W_MEPC    | writing latched PC to mepc
// ST_W_MCAUSE  | writing latched cause to mcause
// ST_W_MSTATUS | writing trap-entry mstatus (MPIE<=MIE, MIE<=0, MPP<=M)
// ST_R_MSTATUS | writing mret mstatus (MIE<=MPIE, MPIE<=1, MPP<=M)
// ST_JUMP      | one-cycle redirect to trap vector or mepc
module clint_trap_ctrl
    import clint_trap_ctrl_pkg::*;
#(
    parameter int VECTORED_EN = 1,
    parameter int XLEN        = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inst_valid_i,
    input  logic [XLEN-1:0]        inst_pc_i,
    input  logic                   ecall_i,
    input  logic                   mret_i,
    input  logic                   global_int_en_i,
    input  logic                   mtime_int_en_i,
    input  logic                   mtime_int_pend_i,
    input  logic [XLEN-1:0]        csr_mtvec_i,
    input  logic [XLEN-1:0]        csr_mepc_i,
    input  logic [XLEN-1:0]        csr_mstatus_i,
    clint_trap_ctrl_if.master      csr_bus,
    output logic                   stall_o,
    output logic                   busy_o
);

    localparam logic [XLEN-1:0] CAUSE_INT_X   = {1'b1, {(XLEN-7){1'b0}}, CAUSE_MTI[5:0]};
    localparam logic [XLEN-1:0] CAUSE_ECALL_X = {{(XLEN-6){1'b0}}, CAUSE_ECALL_M[5:0]};

    state_e          state_q, state_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic            is_int_q, is_int_d;
    logic            is_mret_q, is_mret_d;

    logic            int_take;
    logic            take_now;
    logic            cpu_wen;
    logic [XLEN-1:0] mstatus_trap;
    logic [XLEN-1:0] mstatus_mret;
    logic [XLEN-1:0] trap_target;

    logic            wen;
    logic [11:0]     waddr;
    logic [XLEN-1:0] wdata;
    logic            rvalid;
    logic [XLEN-1:0] rpc;

    assign cpu_wen  = csr_bus.cpu_csr_wen_i;
    assign int_take = global_int_en_i & mtime_int_en_i & mtime_int_pend_i;
    assign take_now = (state_q == ST_IDLE) & inst_valid_i & (int_take | ecall_i | mret_i);

    trap_vec_calc #(
        .VECTORED_EN (VECTORED_EN),
        .XLEN        (XLEN)
    ) u_trap_vec_calc (
        .mtvec_i     (csr_mtvec_i),
        .cause_idx_i (cause_q[5:0]),
        .is_int_i    (is_int_q),
        .target_o    (trap_target)
    );

    // mstatus images for trap entry and for mret, built from the live CSR value.
    always_comb begin
        mstatus_trap = csr_mstatus_i;
        mstatus_trap[MSTATUS_MPIE] = csr_mstatus_i[MSTATUS_MIE];
        mstatus_trap[MSTATUS_MIE]  = 1'b0;
        mstatus_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

        mstatus_mret = csr_mstatus_i;
        mstatus_mret[MSTATUS_MIE]  = csr_mstatus_i[MSTATUS_MPIE];
        mstatus_mret[MSTATUS_MPIE] = 1'b1;
        mstatus_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

    // Next-state: accept in IDLE by priority, hold any write state while the
    // CPU owns the CSR write port so the same write is re-driven next cycle.
    always_comb begin
        state_d   = state_q;
        epc_d     = epc_q;
        cause_d   = cause_q;
        is_int_d  = is_int_q;
        is_mret_d = is_mret_q;
        case (state_q)
            ST_IDLE: begin
                if (inst_valid_i) begin
                    if (int_take) begin
                        epc_d     = inst_pc_i;
                        cause_d   = CAUSE_INT_X;
                        is_int_d  = 1'b1;
                        is_mret_d = 1'b0;
                        state_d   = ST_W_MEPC;
                    end else if (ecall_i) begin
                        epc_d     = inst_pc_i;
                        cause_d   = CAUSE_ECALL_X;
                        is_int_d  = 1'b0;
                        is_mret_d = 1'b0;
                        state_d   = ST_W_MEPC;
                    end else if (mret_i) begin
                        epc_d     = inst_pc_i;
                        cause_d   = '0;
                        is_int_d  = 1'b0;
                        is_mret_d = 1'b1;
                        state_d   = ST_R_MSTATUS;
                    end
                end
            end
            ST_W_MEPC:    if (!cpu_wen) state_d = ST_W_MCAUSE;
            ST_W_MCAUSE:  if (!cpu_wen) state_d = ST_W_MSTATUS;
            ST_W_MSTATUS: if (!cpu_wen) state_d = ST_JUMP;
            ST_R_MSTATUS: if (!cpu_wen) state_d = ST_JUMP;
            ST_JUMP:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // State and latched trap context; reset abandons any sequence in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            epc_q     <= '0;
            cause_q   <= '0;
            is_int_q  <= 1'b0;
            is_mret_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            epc_q     <= epc_d;
            cause_q   <= cause_d;
            is_int_q  <= is_int_d;
            is_mret_q <= is_mret_d;
        end
    end

    // CSR write port and redirect decoded purely from the state register.
    always_comb begin
        wen    = 1'b0;
        waddr  = '0;
        wdata  = '0;
        rvalid = 1'b0;
        rpc    = '0;
        case (state_q)
            ST_W_MEPC: begin
                wen   = 1'b1;
                waddr = ADDR_MEPC;
                wdata = epc_q;
            end
            ST_W_MCAUSE: begin
                wen   = 1'b1;
                waddr = ADDR_MCAUSE;
                wdata = cause_q;
            end
            ST_W_MSTATUS: begin
                wen   = 1'b1;
                waddr = ADDR_MSTATUS;
                wdata = mstatus_trap;
            end
            ST_R_MSTATUS: begin
                wen   = 1'b1;
                waddr = ADDR_MSTATUS;
                wdata = mstatus_mret;
            end
            ST_JUMP: begin
                rvalid = 1'b1;
                rpc    = is_mret_q ? csr_mepc_i : trap_target;
            end
            default: ;
        endcase
    end

    assign csr_bus.clint_csr_wen_o   = wen;
    assign csr_bus.clint_csr_waddr_o = waddr;
    assign csr_bus.clint_csr_wdata_o = wdata;
    assign csr_bus.redirect_valid_o  = rvalid;
    assign csr_bus.redirect_pc_o     = rpc;

    // Stall covers the accept cycle too; forced low while reset is asserted.
    assign stall_o = ~rst & ((state_q != ST_IDLE) | take_now);
    assign busy_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_clint_trap_ctrl.sv
module tb_clint_trap_ctrl;

    localparam int XLEN = 64;

    logic            clk;
    logic            rst;
    logic            inst_valid;
    logic [XLEN-1:0] inst_pc;
    logic            ecall;
    logic            mret;
    logic            gie;
    logic            mtie;
    logic            mtip;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mstatus;
    logic            cpu_wen;
    logic            stall_a, busy_a, stall_b, busy_b;

    int total = 0;
    int bad   = 0;

    clint_trap_ctrl_if #(.XLEN(XLEN)) bus_a ();
    clint_trap_ctrl_if #(.XLEN(XLEN)) bus_b ();

    assign bus_a.cpu_csr_wen_i = cpu_wen;
    assign bus_b.cpu_csr_wen_i = cpu_wen;

    clint_trap_ctrl #(.VECTORED_EN(1), .XLEN(XLEN)) dut_a (
        .clk              (clk),
        .rst              (rst),
        .inst_valid_i     (inst_valid),
        .inst_pc_i        (inst_pc),
        .ecall_i          (ecall),
        .mret_i           (mret),
        .global_int_en_i  (gie),
        .mtime_int_en_i   (mtie),
        .mtime_int_pend_i (mtip),
        .csr_mtvec_i      (mtvec),
        .csr_mepc_i       (mepc),
        .csr_mstatus_i    (mstatus),
        .csr_bus          (bus_a),
        .stall_o          (stall_a),
        .busy_o           (busy_a)
    );

    clint_trap_ctrl #(.VECTORED_EN(0), .XLEN(XLEN)) dut_b (
        .clk              (clk),
        .rst              (rst),
        .inst_valid_i     (inst_valid),
        .inst_pc_i        (inst_pc),
        .ecall_i          (ecall),
        .mret_i           (mret),
        .global_int_en_i  (gie),
        .mtime_int_en_i   (mtie),
        .mtime_int_pend_i (mtip),
        .csr_mtvec_i      (mtvec),
        .csr_mepc_i       (mepc),
        .csr_mstatus_i    (mstatus),
        .csr_bus          (bus_b),
        .stall_o          (stall_b),
        .busy_o           (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks dut_a outputs a little after inputs settle; address/data only
    // when a write is expected, target only when a redirect is expected.
    task automatic chk_out(input string tag, input logic wen, input logic [11:0] wa,
                           input logic [63:0] wd, input logic st, input logic rv,
                           input logic [63:0] rpc, input logic bz);
        #2;
        chk({tag, ".wen"}, 64'(bus_a.clint_csr_wen_o), 64'(wen));
        if (wen) begin
            chk({tag, ".waddr"}, 64'(bus_a.clint_csr_waddr_o), 64'(wa));
            chk({tag, ".wdata"}, bus_a.clint_csr_wdata_o, wd);
        end
        chk({tag, ".stall"}, 64'(stall_a), 64'(st));
        chk({tag, ".rv"}, 64'(bus_a.redirect_valid_o), 64'(rv));
        if (rv) chk({tag, ".rpc"}, bus_a.redirect_pc_o, rpc);
        chk({tag, ".busy"}, 64'(busy_a), 64'(bz));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".wen"},   64'(bus_a.clint_csr_wen_o), 64'd0);
        chk({tag, ".waddr"}, 64'(bus_a.clint_csr_waddr_o), 64'd0);
        chk({tag, ".wdata"}, bus_a.clint_csr_wdata_o, 64'd0);
        chk({tag, ".rv"},    64'(bus_a.redirect_valid_o), 64'd0);
        chk({tag, ".rpc"},   bus_a.redirect_pc_o, 64'd0);
        chk({tag, ".stall"}, 64'(stall_a), 64'd0);
        chk({tag, ".busy"},  64'(busy_a), 64'd0);
    endtask

    initial begin
        rst = 1'b1; inst_valid = 0; inst_pc = '0; ecall = 0; mret = 0;
        gie = 0; mtie = 0; mtip = 0; mtvec = '0; mepc = '0; mstatus = '0; cpu_wen = 0;
        #2;
        chk_all_zero("reset");
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // ecall, direct mode
        mtvec = 64'h8000_0100; mstatus = 64'h1888;
        tick(); inst_valid = 1; inst_pc = 64'h8000_0020; ecall = 1;
        chk_out("ec.T", 0, 12'h0, 64'h0, 1, 0, 64'h0, 0);
        tick(); inst_valid = 0; ecall = 0;
        chk_out("ec.T1", 1, 12'h341, 64'h8000_0020, 1, 0, 64'h0, 1);
        tick(); chk_out("ec.T2", 1, 12'h342, 64'hB, 1, 0, 64'h0, 1);
        tick(); chk_out("ec.T3", 1, 12'h300, 64'h1880, 1, 0, 64'h0, 1);
        tick(); chk_out("ec.T4", 0, 12'h0, 64'h0, 1, 1, 64'h8000_0100, 1);
        tick(); chk_out("ec.T5", 0, 12'h0, 64'h0, 0, 0, 64'h0, 0);

        // timer interrupt, vectored mtvec; dut_b has vectoring disabled
        mtvec = 64'h8000_0101; gie = 1; mtie = 1; mtip = 1;
        tick(); inst_valid = 1; inst_pc = 64'h8000_0040;
        chk_out("int.T", 0, 12'h0, 64'h0, 1, 0, 64'h0, 0);
        tick(); inst_valid = 0;
        chk_out("int.T1", 1, 12'h341, 64'h8000_0040, 1, 0, 64'h0, 1);
        tick(); chk_out("int.T2", 1, 12'h342, 64'h8000_0000_0000_0007, 1, 0, 64'h0, 1);
        tick(); chk_out("int.T3", 1, 12'h300, 64'h1880, 1, 0, 64'h0, 1);
        tick(); mtip = 0;
        chk_out("int.T4", 0, 12'h0, 64'h0, 1, 1, 64'h8000_011C, 1);
        chk("novec.rv", 64'(bus_b.redirect_valid_o), 64'd1);
        chk("novec.rpc", bus_b.redirect_pc_o, 64'h8000_0100);
        tick(); chk_out("int.T5", 0, 12'h0, 64'h0, 0, 0, 64'h0, 0);

        // mret
        gie = 0; mtie = 0; mepc = 64'h8000_0024; mstatus = 64'h1880;
        tick(); inst_valid = 1; inst_pc = 64'h8000_0060; mret = 1;
        chk_out("mret.T", 0, 12'h0, 64'h0, 1, 0, 64'h0, 0);
        tick(); inst_valid = 0; mret = 0;
        chk_out("mret.T1", 1, 12'h300, 64'h1888, 1, 0, 64'h0, 1);
        tick(); chk_out("mret.T2", 0, 12'h0, 64'h0, 1, 1, 64'h8000_0024, 1);
        tick(); chk_out("mret.T3", 0, 12'h0, 64'h0, 0, 0, 64'h0, 0);

        // CPU CSR write collides with mcause for two cycles
        mtvec = 64'h8000_0100; mstatus = 64'h1888;
        tick(); inst_valid = 1; inst_pc = 64'h8000_0030; ecall = 1;
        chk_out("col.T", 0, 12'h0, 64'h0, 1, 0, 64'h0, 0);
        tick(); inst_valid = 0; ecall = 0;
        chk_out("col.T1", 1, 12'h341, 64'h8000_0030, 1, 0, 64'h0, 1);
        tick(); cpu_wen = 1;
        chk_out("col.T2", 1, 12'h342, 64'hB, 1, 0, 64'h0, 1);
        tick(); chk_out("col.T3", 1, 12'h342, 64'hB, 1, 0, 64'h0, 1);
        tick(); cpu_wen = 0;
        chk_out("col.T4", 1, 12'h342, 64'hB, 1, 0, 64'h0, 1);
        tick(); chk_out("col.T5", 1, 12'h300, 64'h1880, 1, 0, 64'h0, 1);
        tick(); chk_out("col.T6", 0, 12'h0, 64'h0, 1, 1, 64'h8000_0100, 1);
        tick(); chk_out("col.T7", 0, 12'h0, 64'h0, 0, 0, 64'h0, 0);

        // interrupt beats a simultaneous ecall
        mtvec = 64'h8000_0101; gie = 1; mtie = 1; mtip = 1;
        tick(); inst_valid = 1; inst_pc = 64'h8000_0050; ecall = 1;
        chk_out("pri.T", 0, 12'h0, 64'h0, 1, 0, 64'h0, 0);
        tick(); inst_valid = 0; ecall = 0; mtip = 0; gie = 0;
        chk_out("pri.T1", 1, 12'h341, 64'h8000_0050, 1, 0, 64'h0, 1);
        tick(); chk_out("pri.T2", 1, 12'h342, 64'h8000_0000_0000_0007, 1, 0, 64'h0, 1);
        tick(); chk_out("pri.T3", 1, 12'h300, 64'h1880, 1, 0, 64'h0, 1);
        tick(); chk_out("pri.T4", 0, 12'h0, 64'h0, 1, 1, 64'h8000_011C, 1);
        tick(); chk_out("pri.T5", 0, 12'h0, 64'h0, 0, 0, 64'h0, 0);

        // ecall beats a simultaneous mret
        mtvec = 64'h8000_0100; mtie = 0;
        tick(); inst_valid = 1; inst_pc = 64'h8000_0070; ecall = 1; mret = 1;
        chk_out("em.T", 0, 12'h0, 64'h0, 1, 0, 64'h0, 0);
        tick(); inst_valid = 0; ecall = 0; mret = 0;
        chk_out("em.T1", 1, 12'h341, 64'h8000_0070, 1, 0, 64'h0, 1);
        tick(); chk_out("em.T2", 1, 12'h342, 64'hB, 1, 0, 64'h0, 1);
        tick(); chk_out("em.T3", 1, 12'h300, 64'h1880, 1, 0, 64'h0, 1);
        tick(); chk_out("em.T4", 0, 12'h0, 64'h0, 1, 1, 64'h8000_0100, 1);
        tick(); chk_out("em.T5", 0, 12'h0, 64'h0, 0, 0, 64'h0, 0);

        // asynchronous reset in the middle of W_MCAUSE
        tick(); inst_valid = 1; inst_pc = 64'h8000_0080; ecall = 1;
        chk_out("rs.T", 0, 12'h0, 64'h0, 1, 0, 64'h0, 0);
        tick(); inst_valid = 0; ecall = 0;
        chk_out("rs.T1", 1, 12'h341, 64'h8000_0080, 1, 0, 64'h0, 1);
        tick(); chk_out("rs.T2", 1, 12'h342, 64'hB, 1, 0, 64'h0, 1);
        #1 rst = 1'b1;
        #1 chk_all_zero("rs.async");
        @(posedge clk); #2;
        rst = 1'b0;
        tick(); chk_out("rs.idle1", 0, 12'h0, 64'h0, 0, 0, 64'h0, 0);
        tick(); chk_out("rs.idle2", 0, 12'h0, 64'h0, 0, 0, 64'h0, 0);
        tick(); chk_out("rs.idle3", 0, 12'h0, 64'h0, 0, 0, 64'h0, 0);

        // full sequence after reset
        tick(); inst_valid = 1; inst_pc = 64'h8000_0090; ecall = 1;
        chk_out("re.T", 0, 12'h0, 64'h0, 1, 0, 64'h0, 0);
        tick(); inst_valid = 0; ecall = 0;
        chk_out("re.T1", 1, 12'h341, 64'h8000_0090, 1, 0, 64'h0, 1);
        tick(); chk_out("re.T2", 1, 12'h342, 64'hB, 1, 0, 64'h0, 1);
        tick(); chk_out("re.T3", 1, 12'h300, 64'h1880, 1, 0, 64'h0, 1);
        tick(); chk_out("re.T4", 0, 12'h0, 64'h0, 1, 1, 64'h8000_0100, 1);
        tick(); chk_out("re.T5", 0, 12'h0, 64'h0, 0, 0, 64'h0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
